// File: rtl/arb_pkg.sv
// Shared types, error-bit positions and grant encoding for the round-robin
// arbitration path.
package arb_pkg;

  localparam int N_DEF     = 4;
  localparam int IDX_W     = (N_DEF > 1) ? $clog2(N_DEF) : 1;
  localparam int MAX_N     = 64;
  localparam int MAX_IDX_W = 6;

  localparam int ERR_BADGRANT = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_ORPHAN   = 2;

  typedef logic [IDX_W-1:0] idx_t;

  // Lowest set bit wins, so a malformed grant still maps to one requester.
  function automatic logic [MAX_IDX_W-1:0] onehot2bin(input logic [MAX_N-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[MAX_IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_tag_fifo.sv
// Tag FIFO recording which requester owns each in-flight request, in
// acceptance order.
module rr_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic [AW:0]  count_reg;
  logic         do_push;
  logic         do_pop;
  logic [W-1:0] mem [DEPTH];

  // Wrap bit distinguishes full from empty when the address bits match.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign head    = mem[rd_ptr_reg[AW-1:0]];
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rr_resp_router.sv
// Steers in-order shared-port responses back to the requester whose grant
// was logged when the request was accepted.
module rr_resp_router
  import arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 512,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             grant,
  input  logic                     req_fire,
  output logic                     tag_full,
  output logic [$clog2(DEPTH):0]   outstanding,
  input  logic                     resp_valid,
  input  logic [DATA_W-1:0]        resp_data,
  output logic                     resp_ready,
  output logic [N-1:0]             out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic [N-1:0]             out_ready,
  output logic [2:0]               err_flags
);
  localparam int TAG_W = (N > 1) ? $clog2(N) : 1;

  logic [MAX_N-1:0]  grant_ext;
  logic [TAG_W-1:0]  grant_tag;
  logic [TAG_W-1:0]  head_tag;
  logic [TAG_W-1:0]  held_tag_reg;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              drain;
  logic              held_reg;
  logic              held_next;
  logic [DATA_W-1:0] out_data_reg;
  logic [2:0]        err_reg;
  logic [2:0]        err_next;

  always_comb begin
    grant_ext        = '0;
    grant_ext[N-1:0] = grant;
  end

  assign grant_tag = TAG_W'(onehot2bin(grant_ext));

  rr_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (grant_tag),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding),
    .head  (head_tag)
  );

  // Full is judged on the pre-pop state, so a push in a full cycle is lost.
  assign tag_full   = fifo_full;
  assign push       = req_fire && !fifo_full;
  assign drain      = held_reg && out_ready[held_tag_reg];
  assign resp_ready = !fifo_empty && (!held_reg || out_ready[held_tag_reg]);
  assign pop        = resp_valid && resp_ready;

  always_comb begin
    held_next = held_reg;
    if (pop)        held_next = 1'b1;
    else if (drain) held_next = 1'b0;
  end

  always_comb begin
    err_next = err_reg;
    if (resp_valid && fifo_empty)       err_next[ERR_ORPHAN]   = 1'b1;
    if (req_fire && fifo_full)          err_next[ERR_OVERFLOW] = 1'b1;
    if (req_fire && !$onehot(grant))    err_next[ERR_BADGRANT] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_reg     <= 1'b0;
      held_tag_reg <= '0;
      out_data_reg <= '0;
      err_reg      <= '0;
    end else begin
      held_reg <= held_next;
      err_reg  <= err_next;
      if (pop) begin
        held_tag_reg <= head_tag;
        out_data_reg <= resp_data;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_valid
    assign out_valid[gi] = held_reg && (held_tag_reg == TAG_W'(gi));
  end

  assign out_data  = out_data_reg;
  assign err_flags = err_reg;

endmodule

// File: tb/tb_rr_resp_router.sv
// Randomized scoreboard bench for rr_resp_router: a stimulus process keeps a
// queue-level reference model, a monitor checks every response handed out.
module tb_rr_resp_router;
  import arb_pkg::*;

  localparam int N      = 4;
  localparam int DATA_W = 512;
  localparam int DEPTH  = 16;
  localparam int IDX_D  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      grant;
  logic              req_fire;
  logic              tag_full;
  logic [IDX_D:0]    outstanding;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_ready;
  logic [N-1:0]      out_valid;
  logic [DATA_W-1:0] out_data;
  logic [N-1:0]      out_ready;
  logic [2:0]        err_flags;

  always #5 clk = ~clk;

  rr_resp_router #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant       (grant),
    .req_fire    (req_fire),
    .tag_full    (tag_full),
    .outstanding (outstanding),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_ready  (resp_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .err_flags   (err_flags)
  );

  typedef struct {
    idx_t              tag;
    logic [DATA_W-1:0] data;
    int                acc;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  idx_t mq[$];
  int   model_cnt;
  logic [2:0] err_exp;
  bit   last_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic chkd(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic idx_t low_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return idx_t'(i);
    return idx_t'(0);
  endfunction

  function automatic logic [DATA_W-1:0] rdata();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: check state against the model, then apply this cycle's inputs to it.
  task automatic cycle();
    int   pre;
    bit   was_full;
    exp_t e;
    @(negedge clk);
    chk("outstanding", 64'(outstanding), 64'(model_cnt));
    chk("tag_full", 64'(tag_full), 64'(model_cnt == DEPTH));
    chk("err_flags", 64'(err_flags), 64'(err_exp));
    pre      = mq.size();
    was_full = (model_cnt == DEPTH);
    if (pre == 0) chk("ready_when_empty", 64'(resp_ready), 64'(0));
    last_acc = 1'b0;
    if (resp_valid && pre == 0) err_exp[2] = 1'b1;
    if (resp_valid && resp_ready && pre > 0) begin
      e.tag  = mq.pop_front();
      e.data = resp_data;
      e.acc  = cyc + 1;
      exp_q.push_back(e);
      model_cnt--;
      last_acc = 1'b1;
    end
    if (req_fire) begin
      if ($countones(grant) != 1) err_exp[0] = 1'b1;
      if (was_full) err_exp[1] = 1'b1;
      else begin
        mq.push_back(low_idx(grant));
        model_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic fire(input logic [N-1:0] g);
    grant    = g;
    req_fire = 1'b1;
    cycle();
    req_fire = 1'b0;
    grant    = '0;
  endtask

  task automatic respond(input logic [DATA_W-1:0] d);
    int n;
    n          = 0;
    resp_valid = 1'b1;
    resp_data  = d;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    chk("resp_accept_timeout", 64'(last_acc), 64'(1));
    resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_fire   = 1'b0;
    grant      = '0;
    resp_valid = 1'b0;
    out_ready  = '1;
    mq.delete();
    exp_q.delete();
    model_cnt  = 0;
    err_exp    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    bit           fresh;
    int           first;
    exp_t         e;
    logic [N-1:0] ev;
    fresh = 1'b1;
    first = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) fresh = 1'b1;
      else if (out_valid != '0) begin
        chk("out_valid_onehot", 64'($countones(out_valid)), 64'(1));
        if (fresh) begin
          first = cyc;
          fresh = 1'b0;
        end
        if ((out_valid & out_ready) != '0) begin
          fresh = 1'b1;
          if (exp_q.size() == 0) chk("unexpected_resp", 64'(out_valid), 64'(0));
          else begin
            e  = exp_q.pop_front();
            ev = '0;
            ev[e.tag] = 1'b1;
            chk("resp_route", 64'(out_valid), 64'(ev));
            chkd("resp_data", out_data, e.data);
            chk("resp_latency", 64'(first), 64'(e.acc));
            $display("resp tag=%0d data=%08h accepted_cyc=%0d", e.tag, out_data[31:0], e.acc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [N-1:0] g;
    int pushed;
    int guard;

    rst_n      = 1'b0;
    grant      = '0;
    req_fire   = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    out_ready  = '1;
    model_cnt  = 0;
    err_exp    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_tag_full", 64'(tag_full), 64'(0));
    chk("rst_err", 64'(err_flags), 64'(0));
    chk("rst_resp_ready", 64'(resp_ready), 64'(0));
    chk("rst_out_data", out_data[63:0], 64'(0));
    rst_n = 1'b1;

    // In-order steering with all requesters ready.
    fire(4'b0001);
    fire(4'b0100);
    fire(4'b0010);
    respond({16{32'hAAAA_0001}});
    respond({16{32'hBBBB_0002}});
    respond({16{32'hCCCC_0003}});
    idle(3);

    // Reset mid-stream with a held response and three tags queued.
    out_ready = '0;
    fire(4'b1000);
    fire(4'b0001);
    fire(4'b0010);
    fire(4'b0100);
    respond(rdata());
    cycle();
    chk("held_before_reset", 64'(out_valid), 64'(4'b1000));
    chk("queued_before_reset", 64'(outstanding), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_outstanding", 64'(outstanding), 64'(0));
    chk("midrst_err", 64'(err_flags), 64'(0));
    do_reset();

    // Fill to DEPTH, then overflow.
    repeat (DEPTH) begin
      g = '0;
      g[$urandom_range(N-1, 0)] = 1'b1;
      fire(g);
    end
    chk("full_flag", 64'(tag_full), 64'(1));
    chk("full_count", 64'(outstanding), 64'(16));
    fire(4'b0001);
    chk("overflow_err", 64'(err_flags), 64'(3'b010));
    chk("overflow_count", 64'(outstanding), 64'(16));
    repeat (DEPTH) respond(rdata());
    idle(2);
    do_reset();

    // Head-of-line blocking on requester 2.
    out_ready = 4'b1011;
    fire(4'b0100);
    fire(4'b0001);
    respond({16{32'hD1D1_0004}});
    resp_valid = 1'b1;
    resp_data  = {16{32'hD2D2_0005}};
    #1;
    chk("hol_block_ready", 64'(resp_ready), 64'(0));
    cycle();
    chk("hol_still_held", 64'(out_valid), 64'(4'b0100));
    out_ready = '1;
    #1;
    chk("hol_release_ready", 64'(resp_ready), 64'(1));
    cycle();
    chk("same_cycle_reload", 64'(last_acc), 64'(1));
    resp_valid = 1'b0;
    chk("reloaded_tag0", 64'(out_valid), 64'(4'b0001));
    idle(2);
    do_reset();

    // Simultaneous push and pop at outstanding=5, then randomized traffic.
    repeat (5) begin
      g = '0;
      g[$urandom_range(N-1, 0)] = 1'b1;
      fire(g);
    end
    grant      = 4'b0010;
    req_fire   = 1'b1;
    resp_valid = 1'b1;
    resp_data  = rdata();
    cycle();
    chk("push_pop_count", 64'(outstanding), 64'(5));
    req_fire   = 1'b0;
    grant      = '0;
    resp_valid = 1'b0;
    pushed = 0;
    guard  = 0;
    while ((pushed < 40 || mq.size() > 0) && guard < 2000) begin
      guard++;
      if (pushed < 40 && model_cnt < DEPTH && $urandom_range(2, 0) != 0) begin
        g = '0;
        g[$urandom_range(N-1, 0)] = 1'b1;
        grant    = g;
        req_fire = 1'b1;
        pushed++;
      end else begin
        grant    = '0;
        req_fire = 1'b0;
      end
      resp_valid = (mq.size() > 0) && ($urandom_range(1, 0) == 1);
      resp_data  = rdata();
      for (int i = 0; i < N; i++) out_ready[i] = ($urandom_range(3, 0) != 0);
      cycle();
    end
    chk("random_phase_done", 64'(guard < 2000), 64'(1));
    req_fire   = 1'b0;
    grant      = '0;
    resp_valid = 1'b0;
    out_ready  = '1;
    idle(3);
    do_reset();

    // Orphan response and malformed grant.
    resp_valid = 1'b1;
    resp_data  = rdata();
    #1;
    chk("orphan_ready", 64'(resp_ready), 64'(0));
    cycle();
    resp_valid = 1'b0;
    chk("orphan_flag", 64'(err_flags[2]), 64'(1));
    fire(4'b0110);
    chk("badgrant_err", 64'(err_flags), 64'(3'b101));
    respond({16{32'hEEEE_0006}});
    idle(3);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
